// File: rtl/button_cmd_arbiter_pkg.sv
// Shared definitions for the button command path: classifier state encoding
// and a width helper that never returns zero.
package button_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_e;

  // Command field layout as seen by consumers: {idx, long}
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Per-button short/long press classifier: edge detect, press FSM and hold counter.
// Events are registered, so they appear one cycle after the deciding sample.
module button_press_classifier
  import button_cmd_arbiter_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = clog2_min1(LONG_PRESS_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic enable_i,
  output logic held_o,
  output logic ev_valid_o,
  output logic ev_long_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  press_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             ev_valid_q, ev_valid_d;
  logic             ev_long_q, ev_long_d;
  logic             rise, fall;

  assign rise = btn_i & ~btn_q;
  assign fall = ~btn_i & btn_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ev_valid_d = 1'b0;
    ev_long_d  = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            ev_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (btn_i && cnt_q == CNT_LAST) begin
            ev_valid_d = 1'b1;
            ev_long_d  = 1'b1;
            state_d    = ST_LONG_HELD;
          end else if (btn_i) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (fall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // btn_q resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      btn_q      <= 1'b1;
      ev_valid_q <= 1'b0;
      ev_long_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_i;
      ev_valid_q <= ev_valid_d;
      ev_long_q  <= ev_long_d;
    end
  end

  assign held_o     = (state_q == ST_PRESSED) || (state_q == ST_LONG_HELD);
  assign ev_valid_o = ev_valid_q;
  assign ev_long_o  = ev_long_q;

endmodule

// File: rtl/button_cmd_arbiter.sv
// Button press classifiers feeding one-deep per-button pending slots,
// round-robin arbitrated onto a registered valid/ready command port.
module button_cmd_arbiter
  import button_cmd_arbiter_pkg::*;
#(
  parameter  int WIDTH             = 4,
  parameter  int LONG_PRESS_CYCLES = 50000000,
  localparam int IDX_W             = clog2_min1(WIDTH),
  localparam int CNT_W             = clog2_min1(LONG_PRESS_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_in,
  input  logic             enable,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDX_W-1:0] cmd_idx,
  output logic             cmd_long,
  output logic [WIDTH-1:0] held,
  output logic             drop
);

  logic [WIDTH-1:0] ev_valid, ev_long;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cls
    button_press_classifier #(
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .CNT_W            (CNT_W)
    ) u_cls (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn_in[g]),
      .enable_i  (enable),
      .held_o    (held[g]),
      .ev_valid_o(ev_valid[g]),
      .ev_long_o (ev_long[g])
    );
  end

  function automatic logic [IDX_W-1:0] rr_pick(input logic [WIDTH-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(ptr) + k) % WIDTH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  logic [WIDTH-1:0] pend_q, pend_d, pend_long_q, pend_long_d, gnt;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, winner;
  logic [IDX_W-1:0] cmd_idx_q, cmd_idx_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_long_q, cmd_long_d;
  logic             drop_q, drop_d, load;

  always_comb begin
    load        = (~cmd_valid_q | cmd_ready) & (|pend_q);
    winner      = rr_pick(pend_q, rr_ptr_q);
    gnt         = load ? (WIDTH'(1) << winner) : '0;
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    drop_d      = 1'b0;
    // A slot being granted this cycle is free to take the new event
    for (int i = 0; i < WIDTH; i++) begin
      if (ev_valid[i]) begin
        if (pend_q[i] && !gnt[i]) begin
          drop_d = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = ev_long[i];
        end
      end else if (gnt[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    cmd_valid_d = cmd_valid_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_long_d  = cmd_long_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_idx_d   = winner;
      cmd_long_d  = pend_long_q[winner];
      rr_ptr_d    = (int'(winner) == WIDTH - 1) ? '0 : winner + 1'b1;
    end else if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_long_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_long_q  <= cmd_long_d;
      drop_q      <= drop_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_long  = cmd_long_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Bench for button_cmd_arbiter: directed scenarios plus random button activity,
// every cycle compared against a press-duration based reference model.
module tb_button_cmd_arbiter;

  localparam int W = 4;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] btn;
  logic         enable;
  logic         cmd_ready;
  logic         cmd_valid;
  logic [1:0]   cmd_idx;
  logic         cmd_long;
  logic [W-1:0] held;
  logic         drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_cmd_arbiter #(.WIDTH(W), .LONG_PRESS_CYCLES(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_idx  (cmd_idx),
    .cmd_long (cmd_long),
    .held     (held),
    .drop     (drop)
  );

  // Reference model: a press is tracked by how many high samples followed its rise
  bit m_prev[W];
  int m_age[W];      // -1 = not timing a press
  bit m_hold[W];     // long press reported, waiting for release
  bit m_ev[W], m_evl[W];
  bit m_pend[W], m_pl[W];
  int m_rr;
  bit m_valid, m_long, m_drop;
  int m_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit any, load, granted, lvl;
    int win, j;
    bit np[W], npl[W];
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        m_prev[i] = 1'b1; m_age[i] = -1; m_hold[i] = 0;
        m_ev[i] = 0; m_evl[i] = 0; m_pend[i] = 0; m_pl[i] = 0;
      end
      m_rr = 0; m_valid = 0; m_long = 0; m_drop = 0; m_idx = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < W; i++) any |= m_pend[i];
    load = (!m_valid || cmd_ready) && any;
    win = -1;
    for (int k = 0; k < W; k++) begin
      j = (m_rr + k) % W;
      if (win < 0 && m_pend[j]) win = j;
    end
    m_drop = 0;
    for (int i = 0; i < W; i++) begin
      np[i] = m_pend[i]; npl[i] = m_pl[i];
      granted = load && (win == i);
      if (m_ev[i]) begin
        if (m_pend[i] && !granted) m_drop = 1;
        else begin np[i] = 1; npl[i] = m_evl[i]; end
      end else if (granted) np[i] = 0;
    end
    if (load) begin
      m_valid = 1; m_idx = win; m_long = m_pl[win]; m_rr = (win + 1) % W;
    end else if (cmd_ready) m_valid = 0;
    for (int i = 0; i < W; i++) begin
      m_pend[i] = np[i]; m_pl[i] = npl[i];
    end
    for (int i = 0; i < W; i++) begin
      lvl = btn[i];
      m_ev[i] = 0; m_evl[i] = 0;
      if (!enable) begin
        m_age[i] = -1; m_hold[i] = 0;
      end else if (m_age[i] >= 0) begin
        if (!lvl) begin
          m_ev[i] = 1; m_age[i] = -1;
        end else begin
          m_age[i]++;
          if (m_age[i] == L) begin
            m_ev[i] = 1; m_evl[i] = 1; m_age[i] = -1; m_hold[i] = 1;
          end
        end
      end else if (m_hold[i]) begin
        if (!lvl) m_hold[i] = 0;
      end else if (lvl && !m_prev[i]) begin
        m_age[i] = 0;
      end
      m_prev[i] = lvl;
    end
  endtask

  task automatic tick();
    logic [W-1:0] eh;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < W; i++) eh[i] = (m_age[i] >= 0) || m_hold[i];
    chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    chk("cmd_idx", 32'(cmd_idx), 32'(m_idx));
    chk("cmd_long", 32'(cmd_long), 32'(m_long));
    chk("held", 32'(held), 32'(eh));
    chk("drop", 32'(drop), 32'(m_drop));
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    btn = v;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; enable = 1'b1; cmd_ready = 1'b1;
    repeat (3) tick();
    chk("reset_valid", 32'(cmd_valid), 32'd0);
    chk("reset_held", 32'(held), 32'd0);
    rst_n = 1'b1;
    tick();

    // short press on button 2
    hold(4'b0100, 3); hold(4'b0000, 6);
    // long press on button 1
    hold(4'b0010, 20); hold(4'b0000, 6);
    // simultaneous releases of 0 and 3, twice
    hold(4'b1001, 3); hold(4'b0000, 6);
    hold(4'b1001, 3); hold(4'b0000, 6);
    // stalled consumer with repeated presses of button 2
    cmd_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin hold(4'b0100, 2); hold(4'b0000, 4); end
    repeat (3) tick();
    cmd_ready = 1'b1;
    repeat (5) tick();
    // button held through reset, then reset mid-press
    btn = 4'b0001; rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1; hold(4'b0001, 4); hold(4'b0000, 3);
    hold(4'b0001, 3); hold(4'b0000, 5);
    hold(4'b0010, 3);
    rst_n = 1'b0; tick();
    chk("midpress_rst_valid", 32'(cmd_valid), 32'd0);
    chk("midpress_rst_held", 32'(held), 32'd0);
    rst_n = 1'b1; hold(4'b0000, 5);
    // enable dropped mid-press, and pending delivery while disabled
    hold(4'b1000, 2);
    enable = 1'b0; hold(4'b1000, 2);
    enable = 1'b1; hold(4'b1000, 2); hold(4'b0000, 5);
    cmd_ready = 1'b0;
    hold(4'b0100, 2); hold(4'b0000, 1);
    hold(4'b0001, 2); hold(4'b0000, 3);
    enable = 1'b0; repeat (2) tick();
    cmd_ready = 1'b1; repeat (4) tick();
    enable = 1'b1; repeat (2) tick();

    // random activity with sticky button levels
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      cmd_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
